// File: rtl/sat_wb_arbiter.sv
// Round-robin write-back arbiter for MAC/ALU results: capture stage, 40-bit saturation stage,
// and sticky per-accumulator saturation flags. Define SAT_CNT_EN to add the saturation event counter.
module sat_wb_arbiter #(
  parameter  int unsigned SEL_W   = 2,
  localparam int unsigned NUM_ACC = 2 ** SEL_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               mac_req_i,
  input  logic [SEL_W-1:0]   mac_acc_sel_i,
  input  logic [39:0]        mac_value_i,
  input  logic               mac_do_sat_i,
  output logic               mac_grant_o,
  input  logic               alu_req_i,
  input  logic [SEL_W-1:0]   alu_acc_sel_i,
  input  logic [39:0]        alu_value_i,
  input  logic               alu_do_sat_i,
  output logic               alu_grant_o,
  input  logic               wb_stall_i,
  output logic               wb_valid_o,
  output logic [SEL_W-1:0]   wb_acc_sel_o,
  output logic [39:0]        wb_value_o,
  output logic               wb_did_sat_o,
`ifdef SAT_CNT_EN
  input  logic               cnt_clr_i,
  output logic [15:0]        sat_cnt_o,
`endif
  input  logic [NUM_ACC-1:0] flag_clr_i,
  output logic [NUM_ACC-1:0] sat_flags_o
);

  localparam int unsigned VAL_W = 40;
  localparam logic [VAL_W-1:0] POS_MAX = 40'h00_7FFF_FFFF;
  localparam logic [VAL_W-1:0] NEG_MIN = 40'hFF_8000_0000;

  logic               last_alu_q,   last_alu_d;
  logic               s1_valid_q,   s1_valid_d;
  logic [SEL_W-1:0]   s1_sel_q,     s1_sel_d;
  logic [VAL_W-1:0]   s1_value_q,   s1_value_d;
  logic               s1_do_sat_q,  s1_do_sat_d;
  logic               wb_valid_q,   wb_valid_d;
  logic [SEL_W-1:0]   wb_sel_q,     wb_sel_d;
  logic [VAL_W-1:0]   wb_value_q,   wb_value_d;
  logic               wb_did_sat_q, wb_did_sat_d;
  logic [NUM_ACC-1:0] flags_q,      flags_d;

  logic [8:0]         guard_c;
  logic               did_sat_c;
  logic [VAL_W-1:0]   sat_value_c;
  logic               accept_c;
  logic [NUM_ACC-1:0] flag_set_c;

  // Arbitration: the requester not granted last wins a tie; nothing is granted in reset or stall.
  always_comb begin
    mac_grant_o = 1'b0;
    alu_grant_o = 1'b0;
    if (!reset_i && !wb_stall_i) begin
      if (mac_req_i && (!alu_req_i || last_alu_q)) begin
        mac_grant_o = 1'b1;
      end else if (alu_req_i) begin
        alu_grant_o = 1'b1;
      end
    end
  end

  // Clamp only when the guard bits and the sign of the 32-bit result disagree.
  always_comb begin
    guard_c     = s1_value_q[39:31];
    did_sat_c   = s1_do_sat_q && !((&guard_c) || !(|guard_c));
    sat_value_c = s1_value_q;
    if (did_sat_c) begin
      sat_value_c = s1_value_q[39] ? NEG_MIN : POS_MAX;
    end
  end

  always_comb begin
    last_alu_d   = last_alu_q;
    s1_valid_d   = s1_valid_q;
    s1_sel_d     = s1_sel_q;
    s1_value_d   = s1_value_q;
    s1_do_sat_d  = s1_do_sat_q;
    wb_valid_d   = wb_valid_q;
    wb_sel_d     = wb_sel_q;
    wb_value_d   = wb_value_q;
    wb_did_sat_d = wb_did_sat_q;
    accept_c     = wb_valid_q && !wb_stall_i;
    flag_set_c   = '0;

    if (mac_grant_o) begin
      last_alu_d = 1'b0;
    end else if (alu_grant_o) begin
      last_alu_d = 1'b1;
    end

    // Both stages advance together; a stall freezes the whole pipe including bubbles.
    if (!wb_stall_i) begin
      s1_valid_d = mac_grant_o || alu_grant_o;
      if (mac_grant_o) begin
        s1_sel_d    = mac_acc_sel_i;
        s1_value_d  = mac_value_i;
        s1_do_sat_d = mac_do_sat_i;
      end else if (alu_grant_o) begin
        s1_sel_d    = alu_acc_sel_i;
        s1_value_d  = alu_value_i;
        s1_do_sat_d = alu_do_sat_i;
      end
      wb_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        wb_sel_d     = s1_sel_q;
        wb_value_d   = sat_value_c;
        wb_did_sat_d = did_sat_c;
      end
    end

    if (accept_c && wb_did_sat_q) begin
      flag_set_c[wb_sel_q] = 1'b1;
    end
    flags_d = (flags_q & ~flag_clr_i) | flag_set_c;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_alu_q   <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_sel_q     <= '0;
      s1_value_q   <= '0;
      s1_do_sat_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_sel_q     <= '0;
      wb_value_q   <= '0;
      wb_did_sat_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      last_alu_q   <= last_alu_d;
      s1_valid_q   <= s1_valid_d;
      s1_sel_q     <= s1_sel_d;
      s1_value_q   <= s1_value_d;
      s1_do_sat_q  <= s1_do_sat_d;
      wb_valid_q   <= wb_valid_d;
      wb_sel_q     <= wb_sel_d;
      wb_value_q   <= wb_value_d;
      wb_did_sat_q <= wb_did_sat_d;
      flags_q      <= flags_d;
    end
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_acc_sel_o = wb_sel_q;
  assign wb_value_o   = wb_value_q;
  assign wb_did_sat_o = wb_did_sat_q;
  assign sat_flags_o  = flags_q;

`ifdef SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        cnt_inc_c;

  // Saturating event counter; a clear coinciding with an event leaves a count of one.
  always_comb begin
    cnt_inc_c = accept_c && wb_did_sat_q;
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr_i) begin
      sat_cnt_d = 16'(cnt_inc_c);
    end else if (cnt_inc_c && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sat_wb_arbiter.sv
// Directed bench for sat_wb_arbiter; covers the SAT_CNT_EN counter when that macro is defined.
module tb_sat_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        mac_req_i, alu_req_i;
  logic [1:0]  mac_acc_sel_i, alu_acc_sel_i;
  logic [39:0] mac_value_i, alu_value_i;
  logic        mac_do_sat_i, alu_do_sat_i;
  logic        mac_grant_o, alu_grant_o;
  logic        wb_stall_i;
  logic        wb_valid_o;
  logic [1:0]  wb_acc_sel_o;
  logic [39:0] wb_value_o;
  logic        wb_did_sat_o;
  logic [3:0]  flag_clr_i;
  logic [3:0]  sat_flags_o;
`ifdef SAT_CNT_EN
  logic        cnt_clr_i;
  logic [15:0] sat_cnt_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  sat_wb_arbiter #(.SEL_W(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mac_req_i(mac_req_i), .mac_acc_sel_i(mac_acc_sel_i), .mac_value_i(mac_value_i),
    .mac_do_sat_i(mac_do_sat_i), .mac_grant_o(mac_grant_o),
    .alu_req_i(alu_req_i), .alu_acc_sel_i(alu_acc_sel_i), .alu_value_i(alu_value_i),
    .alu_do_sat_i(alu_do_sat_i), .alu_grant_o(alu_grant_o),
    .wb_stall_i(wb_stall_i), .wb_valid_o(wb_valid_o), .wb_acc_sel_o(wb_acc_sel_o),
    .wb_value_o(wb_value_o), .wb_did_sat_o(wb_did_sat_o),
`ifdef SAT_CNT_EN
    .cnt_clr_i(cnt_clr_i), .sat_cnt_o(sat_cnt_o),
`endif
    .flag_clr_i(flag_clr_i), .sat_flags_o(sat_flags_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mac(input logic req, input logic [1:0] sel, input logic [39:0] val, input logic sat);
    mac_req_i = req; mac_acc_sel_i = sel; mac_value_i = val; mac_do_sat_i = sat;
  endtask

  task automatic alu(input logic req, input logic [1:0] sel, input logic [39:0] val, input logic sat);
    alu_req_i = req; alu_acc_sel_i = sel; alu_value_i = val; alu_do_sat_i = sat;
  endtask

  initial begin
    reset_i = 1'b1; wb_stall_i = 1'b0; flag_clr_i = 4'b0000;
    mac(1'b1, 2'd0, 40'h0, 1'b0);
    alu(1'b1, 2'd0, 40'h0, 1'b0);
`ifdef SAT_CNT_EN
    cnt_clr_i = 1'b0;
`endif
    #1;
    chk("grant_in_reset_mac", 64'(mac_grant_o), 64'd0);
    chk("grant_in_reset_alu", 64'(alu_grant_o), 64'd0);
    cyc(); cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    alu(1'b0, 2'd0, 40'h0, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_sel", 64'(wb_acc_sel_o), 64'd0);
    chk("rst_value", 64'(wb_value_o), 64'd0);
    chk("rst_did_sat", 64'(wb_did_sat_o), 64'd0);
    chk("rst_flags", 64'(sat_flags_o), 64'd0);

    // MAC-only, in range
    mac(1'b1, 2'd0, 40'h00_1234_5678, 1'b1);
    #1;
    chk("t1_mac_grant", 64'(mac_grant_o), 64'd1);
    chk("t1_alu_grant", 64'(alu_grant_o), 64'd0);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    #1;
    chk("t1_not_yet_valid", 64'(wb_valid_o), 64'd0);
    cyc();
    chk("t1_valid", 64'(wb_valid_o), 64'd1);
    chk("t1_value", 64'(wb_value_o), 64'h00_1234_5678);
    chk("t1_did_sat", 64'(wb_did_sat_o), 64'd0);
    chk("t1_sel", 64'(wb_acc_sel_o), 64'd0);
    cyc();
    chk("t1_valid_drop", 64'(wb_valid_o), 64'd0);

    // ALU positive overflow, then same value without saturation
    alu(1'b1, 2'd2, 40'h01_8000_0000, 1'b1);
    #1;
    chk("t2_alu_grant", 64'(alu_grant_o), 64'd1);
    cyc();
    alu(1'b1, 2'd2, 40'h01_8000_0000, 1'b0);
    cyc();
    alu(1'b0, 2'd0, 40'h0, 1'b0);
    chk("t2_valid", 64'(wb_valid_o), 64'd1);
    chk("t2_value", 64'(wb_value_o), 64'h00_7FFF_FFFF);
    chk("t2_did_sat", 64'(wb_did_sat_o), 64'd1);
    chk("t2_sel", 64'(wb_acc_sel_o), 64'd2);
    cyc();
    chk("t2_flags", 64'(sat_flags_o), 64'b0100);
    chk("t2b_valid", 64'(wb_valid_o), 64'd1);
    chk("t2b_value", 64'(wb_value_o), 64'h01_8000_0000);
    chk("t2b_did_sat", 64'(wb_did_sat_o), 64'd0);
    cyc();
    chk("t2b_flags", 64'(sat_flags_o), 64'b0100);

    // Reset again, then continuous contention alternates starting with MAC
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    #1;
    chk("t3_flags_cleared", 64'(sat_flags_o), 64'd0);
    mac(1'b1, 2'd1, 40'h11, 1'b0);
    alu(1'b1, 2'd3, 40'h22, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        mac(1'b0, 2'd0, 40'h0, 1'b0);
        alu(1'b0, 2'd0, 40'h0, 1'b0);
      end
      #1;
      if (k < 4) begin
        chk("t3_mac_grant", 64'(mac_grant_o), 64'((k % 2) == 0));
        chk("t3_alu_grant", 64'(alu_grant_o), 64'((k % 2) == 1));
      end
      if (k >= 2) begin
        chk("t3_valid", 64'(wb_valid_o), 64'd1);
        chk("t3_value", 64'(wb_value_o), ((k % 2) == 0) ? 64'h11 : 64'h22);
        chk("t3_sel", 64'(wb_acc_sel_o), ((k % 2) == 0) ? 64'd1 : 64'd3);
      end
      cyc();
    end
    chk("t3_valid_end", 64'(wb_valid_o), 64'd0);

    // Saturating write to acc 0 so a later clear has something to remove
    mac(1'b1, 2'd0, 40'h80_0000_0000, 1'b1);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    cyc();
    chk("t4a_value", 64'(wb_value_o), 64'hFF_8000_0000);
    cyc();
    chk("t4a_flags", 64'(sat_flags_o), 64'b0001);

    // Negative overflow to acc 1 held by a 3-cycle stall
    mac(1'b1, 2'd1, 40'hF0_0000_0000, 1'b1);
    #1;
    chk("t4_grant", 64'(mac_grant_o), 64'd1);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    cyc();
    wb_stall_i = 1'b1;
    mac(1'b1, 2'd2, 40'h5, 1'b0);
    alu(1'b1, 2'd3, 40'h6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_mac_grant", 64'(mac_grant_o), 64'd0);
      chk("t4_stall_alu_grant", 64'(alu_grant_o), 64'd0);
      chk("t4_stall_valid", 64'(wb_valid_o), 64'd1);
      chk("t4_stall_value", 64'(wb_value_o), 64'hFF_8000_0000);
      chk("t4_stall_did_sat", 64'(wb_did_sat_o), 64'd1);
      chk("t4_stall_flags", 64'(sat_flags_o), 64'b0001);
      cyc();
    end
    wb_stall_i = 1'b0;
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    alu(1'b0, 2'd0, 40'h0, 1'b0);
    flag_clr_i = 4'b0011;
    #1;
    chk("t4_unstall_value", 64'(wb_value_o), 64'hFF_8000_0000);
    chk("t4_unstall_sel", 64'(wb_acc_sel_o), 64'd1);
    cyc();
    flag_clr_i = 4'b0000;
    chk("t5_flags_set_wins", 64'(sat_flags_o), 64'b0010);
    chk("t4_bubble_after", 64'(wb_valid_o), 64'd0);

    // Reset while an entry is in flight discards it
    mac(1'b1, 2'd3, 40'h77, 1'b0);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("t6_valid_0", 64'(wb_valid_o), 64'd0);
    cyc();
    chk("t6_valid_1", 64'(wb_valid_o), 64'd0);
    cyc();
    chk("t6_valid_2", 64'(wb_valid_o), 64'd0);

`ifdef SAT_CNT_EN
    chk("cnt_reset", 64'(sat_cnt_o), 64'd0);
    mac(1'b1, 2'd3, 40'h40_0000_0000, 1'b1);
    cyc(); cyc(); cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    cyc(); cyc();
    chk("cnt_three", 64'(sat_cnt_o), 64'd3);
    mac(1'b1, 2'd3, 40'h40_0000_0000, 1'b1);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    cyc();
    cnt_clr_i = 1'b1;
    cyc();
    cnt_clr_i = 1'b0;
    chk("cnt_clr_with_inc", 64'(sat_cnt_o), 64'd1);
    force dut.sat_cnt_q = 16'hFFFF;
    cyc();
    release dut.sat_cnt_q;
    mac(1'b1, 2'd3, 40'h40_0000_0000, 1'b1);
    cyc();
    mac(1'b0, 2'd0, 40'h0, 1'b0);
    cyc(); cyc();
    chk("cnt_saturate", 64'(sat_cnt_o), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
